// File: rtl/cpu_axi_bridge.sv
// rtl/cpu_axi_bridge.sv - SRAM-like inst/data ports to a single-outstanding AXI3 master
module cpu_axi_bridge (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR_REQ  = 3'd3,
      WR_RESP = 3'd4
   } state_t;

   state_t      state, state_next;
   logic        src_q, wr_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q, wdata_q;
   logic        aw_done, w_done;
   logic        grant, sel_wr, resp_done;
   logic [1:0]  sel_size;
   logic        unused_rid;

   assign unused_rid = ^rid;

   // Data port has priority; only one port is ever granted per cycle.
   assign data_addr_ok = (state == IDLE) && !reset && data_req;
   assign inst_addr_ok = (state == IDLE) && !reset && inst_req && !data_req;
   assign grant        = data_addr_ok || inst_addr_ok;
   assign sel_wr       = data_req ? data_wr : inst_wr;
   assign sel_size     = data_req ? data_size : inst_size;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant) state_next = sel_wr ? WR_REQ : RD_ADDR;
         RD_ADDR: if (arready) state_next = RD_DATA;
         RD_DATA: if (rvalid) state_next = IDLE;
         WR_REQ:  if ((aw_done || awready) && (w_done || wready)) state_next = WR_RESP;
         WR_RESP: if (bvalid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      arvalid   = 1'b0;
      rready    = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      bready    = 1'b0;
      resp_done = 1'b0;
      case (state)
         RD_ADDR: arvalid = 1'b1;
         RD_DATA: begin
            rready    = 1'b1;
            resp_done = rvalid;
         end
         WR_REQ: begin
            awvalid = !aw_done;
            wvalid  = !w_done;
         end
         WR_RESP: begin
            bready    = 1'b1;
            resp_done = bvalid;
         end
         default: ;
      endcase
   end

   // A reset arriving in the completing cycle abandons the transaction silently.
   assign inst_data_ok = resp_done && !reset && !src_q;
   assign data_data_ok = resp_done && !reset && src_q;
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   always_ff @(posedge clk) begin
      if (grant) begin
         src_q   <= data_req;
         wr_q    <= sel_wr;
         size_q  <= (sel_size == 2'd3) ? 2'd2 : sel_size;
         addr_q  <= data_req ? data_addr : inst_addr;
         wdata_q <= data_req ? data_wdata : inst_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || state != WR_REQ) begin
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (awready) aw_done <= 1'b1;
         if (wready)  w_done  <= 1'b1;
      end
   end

   assign arid   = {3'b000, src_q};
   assign araddr = addr_q;
   assign arsize = {1'b0, size_q};
   assign awaddr = addr_q;
   assign awsize = {1'b0, size_q};
   assign wdata  = wdata_q;

   always_comb begin
      case (size_q)
         2'd0:    wstrb = 4'b0001 << addr_q[1:0];
         2'd1:    wstrb = 4'b0011 << {addr_q[1], 1'b0};
         default: wstrb = 4'b1111;
      endcase
   end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb/tb_cpu_axi_bridge.sv - directed bench with a transaction-level model of cpu_axi_bridge
module tb_cpu_axi_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic [3:0]  arid, rid, wstrb;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rvalid, rready;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cpu_axi_bridge dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one pending transaction plus which AXI handshakes it has completed.
   bit          m_busy = 0, m_src, m_wr, m_ar, m_aw, m_w;
   int          m_size;
   logic [31:0] m_addr, m_wdata;

   function automatic logic [3:0] model_strb(int size, logic [31:0] addr);
      if (size == 0) return 4'(1 << (addr % 4));
      if (size == 1) return 4'(3 << (addr & 2));
      return 4'hF;
   endfunction

   always @(negedge clk) begin
      bit e_dg, e_ig, e_ar, e_r, e_aw, e_w, e_b, e_done;
      e_dg   = !m_busy && !reset && data_req;
      e_ig   = !m_busy && !reset && inst_req && !data_req;
      e_ar   = m_busy && !m_wr && !m_ar;
      e_r    = m_busy && !m_wr && m_ar;
      e_aw   = m_busy && m_wr && !m_aw;
      e_w    = m_busy && m_wr && !m_w;
      e_b    = m_busy && m_wr && m_aw && m_w;
      e_done = !reset && ((e_r && rvalid) || (e_b && bvalid));

      chk("data_addr_ok", 32'(data_addr_ok), 32'(e_dg));
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_ig));
      chk("arvalid", 32'(arvalid), 32'(e_ar));
      chk("rready", 32'(rready), 32'(e_r));
      chk("awvalid", 32'(awvalid), 32'(e_aw));
      chk("wvalid", 32'(wvalid), 32'(e_w));
      chk("bready", 32'(bready), 32'(e_b));
      chk("data_data_ok", 32'(data_data_ok), 32'(e_done && m_src));
      chk("inst_data_ok", 32'(inst_data_ok), 32'(e_done && !m_src));
      chk("addr_ok_vs_data_ok", 32'((inst_addr_ok || data_addr_ok) && (inst_data_ok || data_data_ok)), 32'd0);
      if (e_ar) begin
         chk("araddr", araddr, m_addr);
         chk("arsize", 32'(arsize), 32'(m_size));
         chk("arid", 32'(arid), 32'(m_src));
      end
      if (e_aw) begin
         chk("awaddr", awaddr, m_addr);
         chk("awsize", 32'(awsize), 32'(m_size));
      end
      if (e_w) begin
         chk("wdata", wdata, m_wdata);
         chk("wstrb", 32'(wstrb), 32'(model_strb(m_size, m_addr)));
      end
      if (e_done && !m_wr)
         chk("port_rdata", m_src ? data_rdata : inst_rdata, rdata);

      if (reset) begin
         m_busy = 0;
      end else if (e_dg || e_ig) begin
         m_busy  = 1;
         m_src   = e_dg;
         m_wr    = e_dg ? data_wr : inst_wr;
         m_size  = e_dg ? int'(data_size) : int'(inst_size);
         if (m_size == 3) m_size = 2;
         m_addr  = e_dg ? data_addr : inst_addr;
         m_wdata = e_dg ? data_wdata : inst_wdata;
         m_ar = 0; m_aw = 0; m_w = 0;
      end else if (m_busy) begin
         if (e_ar && arready) m_ar = 1;
         if (e_aw && awready) m_aw = 1;
         if (e_w && wready)   m_w = 1;
         if (e_done)          m_busy = 0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   task automatic quiet();
      inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
      arready = 0; rid = '0; rdata = '0; rvalid = 0;
      awready = 0; wready = 0; bvalid = 0;
   endtask

   task automatic req(input bit src, input bit wr, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wd);
      if (src) begin
         data_req = 1; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
      end else begin
         inst_req = 1; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
      end
   endtask

   // Best-case read: AR accepted at N+1, R returned at N+2.
   task automatic do_read(input bit src, input logic [31:0] addr, input logic [31:0] rd,
                          input logic [3:0] exp_id);
      req(src, 0, 2'd2, addr, '0);
      look();
      chk("L_rd_addr_ok", 32'(src ? data_addr_ok : inst_addr_ok), 32'd1);
      cyc();
      inst_req = 0; data_req = 0; arready = 1;
      look();
      chk("L_rd_arid", 32'(arid), 32'(exp_id));
      chk("L_rd_araddr", araddr, addr);
      cyc();
      arready = 0; rvalid = 1; rdata = rd;
      look();
      chk("L_rd_data_ok", 32'(src ? data_data_ok : inst_data_ok), 32'd1);
      chk("L_rd_rdata", src ? data_rdata : inst_rdata, rd);
      cyc();
      rvalid = 0;
   endtask

   task automatic do_write(input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] exp_strb,
                           input logic [2:0] exp_awsize);
      req(1, 1, size, addr, wd);
      look();
      chk("L_wr_addr_ok", 32'(data_addr_ok), 32'd1);
      cyc();
      data_req = 0; awready = 1; wready = 1;
      look();
      chk("L_wr_valids", {30'd0, awvalid, wvalid}, 32'd3);
      chk("L_wr_wstrb", 32'(wstrb), 32'(exp_strb));
      chk("L_wr_awsize", 32'(awsize), 32'(exp_awsize));
      cyc();
      awready = 0; wready = 0; bvalid = 1;
      look();
      chk("L_wr_data_ok", 32'(data_data_ok), 32'd1);
      cyc();
      bvalid = 0;
   endtask

   initial begin
      reset = 1;
      quiet();
      cyc(); cyc();
      reset = 0;
      look();
      chk("L_rst_outputs", {23'd0, arvalid, rready, awvalid, wvalid, bready,
                            inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
      cyc();

      // Word read from the data port
      do_read(1, 32'h1FC0_0010, 32'hDEAD_BEEF, 4'd1);

      // Simultaneous requests: data wins, instruction waits for the next IDLE cycle
      req(0, 0, 2'd2, 32'h0000_0100, '0);
      req(1, 0, 2'd2, 32'h0000_0200, '0);
      look();
      chk("L_sim_data_ok", 32'(data_addr_ok), 32'd1);
      chk("L_sim_inst_ok", 32'(inst_addr_ok), 32'd0);
      cyc();
      data_req = 0; arready = 1;
      look();
      chk("L_sim_arsize", 32'(arsize), 32'd2);
      cyc();
      arready = 0; rvalid = 1; rdata = 32'h1122_3344;
      look();
      chk("L_sim_data_data_ok", 32'(data_data_ok), 32'd1);
      cyc();
      rvalid = 0;
      look();
      chk("L_sim_inst_granted", 32'(inst_addr_ok), 32'd1);
      cyc();
      inst_req = 0; arready = 1;
      look();
      chk("L_sim_inst_arid", 32'(arid), 32'd0);
      cyc();
      arready = 0; rvalid = 1; rdata = 32'h5566_7788;
      look();
      chk("L_sim_inst_data_ok", 32'(inst_data_ok), 32'd1);
      cyc();
      rvalid = 0;

      // Sub-word and word stores (size 3 behaves as a word)
      do_write(2'd0, 32'h8000_0003, 32'h7777_7777, 4'b1000, 3'd0);
      do_write(2'd1, 32'h8000_0002, 32'h1234_1234, 4'b1100, 3'd1);
      do_write(2'd3, 32'h8000_0004, 32'hA5A5_5A5A, 4'b1111, 3'd2);

      // Split AW/W: W accepted at once, AW stalled three cycles
      req(1, 1, 2'd2, 32'h8000_1000, 32'hCAFE_F00D);
      cyc();
      data_req = 0; wready = 1;
      look();
      chk("L_split_both_valid", {30'd0, awvalid, wvalid}, 32'd3);
      cyc();
      wready = 0;
      look();
      chk("L_split_w_dropped", {30'd0, awvalid, wvalid}, 32'd2);
      chk("L_split_no_bready", 32'(bready), 32'd0);
      cyc();
      cyc();
      awready = 1;
      look();
      chk("L_split_awaddr", awaddr, 32'h8000_1000);
      cyc();
      awready = 0;
      look();
      chk("L_split_bready", {30'd0, awvalid, bready}, 32'd1);
      cyc();
      bvalid = 1;
      look();
      chk("L_split_data_ok", 32'(data_data_ok), 32'd1);
      cyc();
      bvalid = 0;

      // AR stall of five cycles with an instruction request waiting
      req(1, 0, 2'd1, 32'h0000_0042, '0);
      cyc();
      data_req = 0;
      req(0, 0, 2'd2, 32'h0000_0300, '0);
      for (int i = 0; i < 5; i++) begin
         look();
         chk("L_stall_inst_locked", 32'(inst_addr_ok), 32'd0);
         chk("L_stall_araddr", araddr, 32'h0000_0042);
         cyc();
      end
      arready = 1;
      cyc();
      arready = 0; rvalid = 1; rdata = 32'h0BAD_CAFE; inst_req = 0;
      look();
      chk("L_stall_data_ok", 32'(data_data_ok), 32'd1);
      cyc();
      rvalid = 0;

      // Reset while waiting for read data, then a clean instruction read
      req(1, 0, 2'd2, 32'h0000_0080, '0);
      cyc();
      data_req = 0; arready = 1;
      cyc();
      arready = 0; reset = 1;
      look();
      chk("L_rst_mid_no_ok", 32'(data_data_ok), 32'd0);
      cyc();
      reset = 0; rvalid = 1; rdata = 32'hFFFF_0000;
      look();
      chk("L_rst_mid_outputs", {23'd0, arvalid, rready, awvalid, wvalid, bready,
                                inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
      cyc();
      rvalid = 0;
      do_read(0, 32'hBFC0_0000, 32'h3C1D_BFC0, 4'd0);

      cyc(); cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
